stream_loader: RTL and testbench
================================

Name: stream_loader

Overview:
- Consumer end of the sequential pull-stream interface used by the design's ROM image streamers (source presents one byte per `ce` pulse, with 1-cycle registered latency, and an auto-incrementing internal address).
- Pulls exactly LEN bytes from such a source and packs them little-endian into DW-bit words.
- Writes each word into system RAM through a req/ack write port. Used to copy BIOS/boot images into RAM at power-up.

Parameters:
- AW, 18, RAM word-address width
- DW, 16, RAM word width; must be a multiple of 8
- LW, 18, byte-length counter width

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  1-cycle pulse; begins a load, sampled only in IDLE
- base_addr  in  AW  first RAM word address, latched on start
- length  in  LW  byte count to load, latched on start
- src_ce  out  1  pull strobe to byte source
- src_data  in  8  source byte, valid the cycle after src_ce
- mem_addr  out  AW  RAM word address
- mem_data  out  DW  packed word
- mem_be  out  DW/8  byte enables, bit i covers mem_data[8i+7:8i]
- mem_we  out  1  write request, held until acknowledged
- mem_ack  in  1  write accepted this cycle when mem_we=1
- busy  out  1  high from cycle after start until done
- done  out  1  1-cycle pulse when the load completes

Behaviour:
- Clock and reset are decided: one clock `clock`; `reset` is synchronous and active-high.
- Reset values: src_ce=0, mem_we=0, mem_addr=0, mem_data=0, mem_be=0, busy=0, done=0, state=IDLE, all counters=0.
- Reset mid-load aborts immediately to IDLE. A partially packed word is discarded, and any held mem_we drops the cycle after reset.
- States: IDLE, PULL, CAPT, WRITE, FIN.
- IDLE:
  - start=1 latches base_addr, length, lane=0, and sets busy.
  - If length==0, go to FIN. Otherwise go to PULL.
- PULL:
  - src_ce=1 for exactly one cycle, then go to CAPT.
- CAPT:
  - Latch src_data into byte lane `lane` of the word register and set the matching be bit.
  - Decrement the remaining byte count and increment lane.
  - If the word is full (lane==DW/8-1) or remaining reaches 0, go to WRITE. Otherwise go to PULL.
- WRITE:
  - Drive mem_we=1, with mem_addr/mem_data/mem_be stable until mem_ack.
  - On ack: mem_we deasserts the next cycle, mem_addr increments, the word register and be clear, and lane=0.
  - Then go to PULL if bytes remain, else FIN.
  - mem_ack while mem_we=0 is ignored.
- FIN:
  - Pulse done=1 for one cycle, clear busy, go to IDLE.
- Byte order is little-endian: the first byte pulled goes to lane 0.
- Final partial word: unused lanes are 0 with mem_be bits cleared. Example: DW=16, length=3 gives be=2'b11 then 2'b01.
- Throughput: 2 cycles per byte plus at least 1 cycle per word write.
- Source pulls: exactly `length` src_ce pulses per load, never more, and never a pull while mem_we is pending.
- The source address is owned by the source. The loader never resets it; successive loads continue the source stream.
- start asserted while busy is ignored.
- mem_addr wraps modulo 2^AW with no error.
- length is LW bits and is treated as unsigned.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/PULL/CAPT/WRITE/FIN)
  - constant BPW=DW/8
  - lane-index width $clog2(BPW)
- One natural sub-module, byte_packer: lane register, be accumulation, clear-on-write.
- The FSM and counters stay in stream_loader.

Test Plan:
- DW=16, base=0x100, length=4, source bytes 11,22,33,44, mem_ack immediate -> writes 0x2211@0x100 be=11, then 0x4433@0x101 be=11; exactly 4 src_ce pulses; one done pulse; busy low afterwards.
- length=3, bytes AA,BB,CC -> 0xBBAA@base be=11, then 0x00CC@base+1 be=01; done.
- length=0 -> no src_ce, no mem_we, done pulses 2 cycles after start.
- mem_ack delayed 5 cycles on each write -> mem_we/addr/data/be held stable for all 5 cycles; no src_ce during the wait; final RAM contents identical to the immediate-ack case.
- reset asserted in CAPT after 1 byte of a 6-byte load -> all outputs 0 the next cycle; no mem_we or done; a subsequent start performs a clean full load.
- start re-pulsed while busy, and base=2^AW-1 with length=4 -> the second start is ignored; writes land at 2^AW-1 then wrap to 0.

Source files
------------

// File: rtl/stream_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : stream_loader_pkg                                         |
// | Brief    : Shared state encoding and word/lane geometry constants.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package stream_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PULL  = 3'd1,
    ST_CAPT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  localparam int c_DW     = 16;
  localparam int c_BPW    = c_DW / 8;
  localparam int c_LANE_W = (c_BPW > 1) ? $clog2(c_BPW) : 1;

  // A byte-wide word still needs a 1-bit lane index to stay a legal vector.
  function automatic int lane_width(input int dw);
    return ((dw / 8) > 1) ? $clog2(dw / 8) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_loader_byte_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : stream_loader_byte_packer                                 |
// | Brief    : Little-endian byte-to-word packer with byte-enable track.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module stream_loader_byte_packer
  import stream_loader_pkg::*;
#(
  parameter int DW = c_DW
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            capture,
  input  logic [7:0]      byte_in,
  output logic [DW-1:0]   word,
  output logic [DW/8-1:0] be,
  output logic            last_lane
);

  localparam int c_NB     = DW / 8;
  localparam int c_LANE_B = lane_width(DW);

  logic [c_LANE_B-1:0] r_lane;
  logic [DW-1:0]       r_word;
  logic [c_NB-1:0]     r_be;

  assign word      = r_word;
  assign be        = r_be;
  assign last_lane = (r_lane == c_LANE_B'(c_NB - 1));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_word <= '0;
      r_be   <= '0;
      r_lane <= '0;
    end else if (capture) begin
      r_word[8*r_lane +: 8] <= byte_in;
      r_be[r_lane]          <= 1'b1;
      r_lane                <= last_lane ? '0 : r_lane + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : stream_loader                                             |
// | Brief    : Pulls LEN bytes from a pull-stream source into RAM words.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module stream_loader
  import stream_loader_pkg::*;
#(
  parameter int AW = 18,
  parameter int DW = c_DW,
  parameter int LW = 18
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [AW-1:0]   base_addr,
  input  logic [LW-1:0]   length,
  output logic            src_ce,
  input  logic [7:0]      src_data,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_data,
  output logic [DW/8-1:0] mem_be,
  output logic            mem_we,
  input  logic            mem_ack,
  output logic            busy,
  output logic            done
);

  state_t        r_state;
  logic [LW-1:0] r_remaining;
  logic [AW-1:0] r_addr;

  logic w_capture;
  logic w_clear;
  logic w_last_lane;

  assign mem_addr  = r_addr;
  assign w_capture = (r_state == ST_CAPT);
  assign w_clear   = ((r_state == ST_IDLE) && start) ||
                     ((r_state == ST_WRITE) && mem_ack);

  stream_loader_byte_packer #(
    .DW (DW)
  ) u_packer (
    .clock     (clock),
    .reset     (reset),
    .clear     (w_clear),
    .capture   (w_capture),
    .byte_in   (src_data),
    .word      (mem_data),
    .be        (mem_be),
    .last_lane (w_last_lane)
  );

  // src_ce and mem_we are raised on entry to PULL/WRITE so they line up
  // with the state they belong to.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_addr      <= '0;
      src_ce      <= 1'b0;
      mem_we      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr      <= base_addr;
            r_remaining <= length;
            busy        <= 1'b1;
            if (length == '0) begin
              r_state <= ST_FIN;
            end else begin
              src_ce  <= 1'b1;
              r_state <= ST_PULL;
            end
          end
        end
        ST_PULL: begin
          src_ce  <= 1'b0;
          r_state <= ST_CAPT;
        end
        ST_CAPT: begin
          r_remaining <= r_remaining - 1'b1;
          if (w_last_lane || (r_remaining == LW'(1))) begin
            mem_we  <= 1'b1;
            r_state <= ST_WRITE;
          end else begin
            src_ce  <= 1'b1;
            r_state <= ST_PULL;
          end
        end
        ST_WRITE: begin
          if (mem_ack) begin
            mem_we <= 1'b0;
            r_addr <= r_addr + 1'b1;
            if (r_remaining != '0) begin
              src_ce  <= 1'b1;
              r_state <= ST_PULL;
            end else begin
              r_state <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_stream_loader                                          |
// | Brief    : Scoreboard bench for stream_loader with a pull-byte source.|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_stream_loader;

  localparam int AW = 18;
  localparam int DW = 16;
  localparam int LW = 18;
  localparam int NB = DW / 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [NB-1:0] be;
  } wr_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] length;
  logic          src_ce;
  logic [7:0]    src_data = 8'h00;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [NB-1:0] mem_be;
  logic          mem_we;
  logic          mem_ack = 1'b0;
  logic          busy;
  logic          done;

  stream_loader #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .src_ce    (src_ce),
    .src_data  (src_data),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_be    (mem_be),
    .mem_we    (mem_we),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte source: registered data one cycle after ce, address never reset.
  logic [7:0] src_mem [256];
  logic [7:0] src_ptr = 8'h00;
  always @(posedge clock) begin
    if (src_ce) begin
      src_data <= src_mem[src_ptr];
      src_ptr  <= src_ptr + 8'h01;
    end
  end

  wr_t exp_q[$];
  wr_t cur;
  bit  in_write  = 1'b0;
  int  wait_cnt  = 0;
  int  ack_delay = 0;
  bit  stray_ack = 1'b0;
  int  ce_cnt    = 0;
  int  done_cnt  = 0;
  int  wr_cnt    = 0;

  always @(negedge clock) begin
    if (src_ce) ce_cnt++;
    if (done) done_cnt++;
    if (reset) begin
      mem_ack  = 1'b0;
      in_write = 1'b0;
      wait_cnt = 0;
    end else if (mem_we) begin
      if (!in_write) begin
        in_write = 1'b1;
        wait_cnt = 0;
        wr_cnt++;
        chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) cur = exp_q.pop_front();
      end
      chk("mem_addr", 64'(mem_addr), 64'(cur.addr));
      chk("mem_data", 64'(mem_data), 64'(cur.data));
      chk("mem_be", 64'(mem_be), 64'(cur.be));
      chk("ce_in_write", 64'(src_ce), 64'd0);
      mem_ack = (wait_cnt >= ack_delay);
      wait_cnt++;
    end else begin
      in_write = 1'b0;
      wait_cnt = 0;
      mem_ack  = stray_ack;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  logic [7:0] pat [8];

  // Independent reference packing of pat[0..len-1] into expected writes.
  task automatic push_expected(input logic [AW-1:0] base, input int len);
    wr_t w;
    logic [AW-1:0] a;
    int lane;
    a = base;
    w.data = '0;
    w.be = '0;
    for (int j = 0; j < len; j++) begin
      lane = j % NB;
      w.data[8*lane +: 8] = pat[j];
      w.be[lane] = 1'b1;
      if (lane == NB - 1 || j == len - 1) begin
        w.addr = a;
        exp_q.push_back(w);
        a = a + 1'b1;
        w.data = '0;
        w.be = '0;
      end
    end
  endtask

  task automatic fill_source(input int len);
    for (int j = 0; j < len; j++) src_mem[8'(int'(src_ptr) + j)] = pat[j];
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input int len);
    base_addr = b;
    length    = LW'(len);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic run_load(input logic [AW-1:0] base, input int len,
                          input int delay, input bit repulse, input bit stray);
    bit seen;
    fill_source(len);
    push_expected(base, len);
    ack_delay = delay;
    stray_ack = stray;
    ce_cnt    = 0;
    done_cnt  = 0;
    wr_cnt    = 0;
    pulse_start(base, len);
    if (repulse) begin
      tick();
      tick();
      pulse_start(AW'(12'h234), 2);
    end
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (done) seen = 1'b1;
      else tick();
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    tick();
    chk("done_pulse_1cyc", 64'(done), 64'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("src_ce_count", 64'(ce_cnt), 64'(len));
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("write_count", 64'(wr_cnt), 64'((len + NB - 1) / NB));
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    stray_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit hit;
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    for (int i = 0; i < 256; i++) src_mem[i] = 8'h00;
    for (int i = 0; i < 3; i++) tick();
    chk("reset_outputs", 64'({src_ce, mem_we, busy, done, mem_addr, mem_data, mem_be}), 64'd0);
    reset = 1'b0;
    tick();

    // Two full words, immediate ack.
    pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load(AW'(12'h100), 4, 0, 1'b0, 1'b0);

    // Odd length leaves a half-filled final word; stray acks while idle-writes.
    pat = '{8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load(AW'(12'h200), 3, 0, 1'b0, 1'b1);

    // Zero length: done two cycles after start, no traffic.
    ce_cnt = 0; done_cnt = 0; wr_cnt = 0;
    pulse_start(AW'(12'h300), 0);
    chk("len0_busy", 64'(busy), 64'd1);
    chk("len0_done_early", 64'(done), 64'd0);
    tick();
    chk("len0_done", 64'(done), 64'd1);
    chk("len0_busy_clr", 64'(busy), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("len0_ce", 64'(ce_cnt), 64'd0);
    chk("len0_writes", 64'(wr_cnt), 64'd0);
    chk("len0_done_cnt", 64'(done_cnt), 64'd1);

    // Slow RAM: five-cycle ack latency on every write.
    pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load(AW'(12'h400), 4, 5, 1'b0, 1'b0);

    // Reset while capturing the first byte of a six-byte load.
    pat = '{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E, 8'hAF, 8'h00, 8'h00};
    fill_source(6);
    ce_cnt = 0; done_cnt = 0; wr_cnt = 0;
    ack_delay = 0;
    pulse_start(AW'(12'h055), 6);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (ce_cnt == 1) hit = 1'b1;
      else tick();
    end
    chk("abort_pull_seen", 64'(hit), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    chk("abort_outputs", 64'({src_ce, mem_we, busy, done, mem_addr, mem_data, mem_be}), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("abort_ce", 64'(ce_cnt), 64'd1);
    chk("abort_done", 64'(done_cnt), 64'd0);
    chk("abort_writes", 64'(wr_cnt), 64'd0);

    // Clean reload afterwards continues from the source's current position.
    pat = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00};
    run_load(AW'(12'h600), 6, 1, 1'b0, 1'b0);

    // Top-of-memory base wraps; a second start while busy is ignored.
    pat = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load({AW{1'b1}}, 4, 0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
